rob_ctl: RTL

- Sequencer for the array of ROB entries: owns the allocation (tail) and retirement (head) pointers.
- Drives per-entry alloc/retire strobes and the broadcast flush strobe; reports retirement and flush to the rest of the core.
- Sits between decode (alloc in de1) and the retire stage (rb1). The entries themselves stay passive state holders.

---
 rtl/rob_defs_pkg.sv | 31 +++
 rtl/rob_ctl_ptr.sv | 24 ++
 rtl/rob_ctl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/rob_defs_pkg.sv
// Shared ROB types: entry payloads, wrap-bit pointer and the control FSM encoding.
package rob_defs;

    localparam int RB_NUM_ENTS = 16;
    localparam int RB_ID_W     = $clog2(RB_NUM_ENTS);

    typedef logic [RB_ID_W-1:0] t_rob_id;
    typedef logic [31:0]        t_rv_reg_data;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rd_vld;
        logic        is_br;
    } t_rob_ent_static;

    typedef struct packed {
        logic    wrap;
        t_rob_id idx;
    } t_rob_ptr;

    typedef enum logic {
        CTL_RUN   = 1'b0,
        CTL_FLUSH = 1'b1
    } t_rob_ctl_fsm;

    function automatic logic [RB_NUM_ENTS-1:0] rob_onehot(input t_rob_id i);
        return {{(RB_NUM_ENTS-1){1'b0}}, 1'b1} << i;
    endfunction

endpackage

// File: rtl/rob_ctl_ptr.sv
// Wrap-bit ROB pointer: counts modulo 2*RB_NUM_ENTS, clear wins over increment.
module rob_ptr
    import rob_defs::*;
(
    input  logic     clk,
    input  logic     i_srst,
    input  logic     i_inc,
    input  logic     i_clr,
    output t_rob_ptr o_ptr
);

    logic [RB_ID_W:0] r_ptr;

    always_ff @(posedge clk) begin
        if (i_srst || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/rob_ctl.sv
// ROB sequencer: owns head/tail pointers, alloc/retire strobes and flush recovery.
// Define ROB_CTL_PERF_EN to add saturating retire/flush/full-stall counters.
module rob_ctl
    import rob_defs::*;
(
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                de1_alloc_req,
    input  t_rob_ent_static                     de1_alloc_s,
    output logic                                de1_alloc_rdy,
    output t_rob_id                             de1_alloc_robid,
    output logic [RB_NUM_ENTS-1:0]              e_alloc_de1,
    output t_rob_ent_static                     q_alloc_s_de1,
    input  logic [RB_NUM_ENTS-1:0]              e_valid,
    input  logic [RB_NUM_ENTS-1:0]              e_ready,
    input  logic [RB_NUM_ENTS-1:0]              e_flush_needed,
    input  t_rv_reg_data [RB_NUM_ENTS-1:0]      e_result,
    output logic [RB_NUM_ENTS-1:0]              e_retire_rb1,
    output logic                                q_flush_now_rb1,
    output logic                                rb1_retire_vld,
    output t_rob_id                             rb1_retire_robid,
    output t_rv_reg_data                        rb1_retire_result,
    output logic                                rb1_flush_vld,
    output t_rob_id                             rb1_flush_robid
`ifdef ROB_CTL_PERF_EN
    ,
    output logic [31:0]                         perf_retired,
    output logic [31:0]                         perf_flushes,
    output logic [31:0]                         perf_full_stalls
`endif
);

    t_rob_ptr     w_head;
    t_rob_ptr     w_tail;
    t_rob_ctl_fsm r_fsm;
    t_rob_ctl_fsm w_fsm_next;

    logic w_run;
    logic w_empty;
    logic w_full;
    logic w_head_live;
    logic w_flush;
    logic w_retire;
    logic w_alloc;

    assign w_run   = !reset && (r_fsm == CTL_RUN);
    assign w_empty = (w_head == w_tail);
    assign w_full  = (w_head.idx == w_tail.idx) && (w_head.wrap != w_tail.wrap);

    // A mispredicting head flushes instead of retiring, even if it also reports ready.
    assign w_head_live = w_run && !w_empty && e_valid[w_head.idx];
    assign w_flush     = w_head_live && e_flush_needed[w_head.idx];
    assign w_retire    = w_head_live && e_ready[w_head.idx] && !e_flush_needed[w_head.idx];

    assign de1_alloc_rdy = w_run && !w_full && !w_flush;
    assign w_alloc       = de1_alloc_req && de1_alloc_rdy;

    rob_ptr u_head (
        .clk    (clk),
        .i_srst (reset),
        .i_inc  (w_retire),
        .i_clr  (w_flush),
        .o_ptr  (w_head)
    );

    rob_ptr u_tail (
        .clk    (clk),
        .i_srst (reset),
        .i_inc  (w_alloc),
        .i_clr  (w_flush),
        .o_ptr  (w_tail)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm <= CTL_RUN;
        end else begin
            r_fsm <= w_fsm_next;
        end
    end

    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            CTL_RUN:   if (w_flush) w_fsm_next = CTL_FLUSH;
            CTL_FLUSH: w_fsm_next = CTL_RUN;
            default:   w_fsm_next = CTL_RUN;
        endcase
    end

    assign de1_alloc_robid   = w_tail.idx;
    assign e_alloc_de1       = w_alloc ? rob_onehot(w_tail.idx) : '0;
    assign q_alloc_s_de1     = de1_alloc_s;
    assign e_retire_rb1      = w_retire ? rob_onehot(w_head.idx) : '0;
    assign q_flush_now_rb1   = w_flush;
    assign rb1_retire_vld    = w_retire;
    assign rb1_retire_robid  = w_retire ? w_head.idx : '0;
    assign rb1_retire_result = w_retire ? e_result[w_head.idx] : '0;
    assign rb1_flush_vld     = w_flush;
    assign rb1_flush_robid   = w_flush ? w_head.idx : '0;

`ifdef ROB_CTL_PERF_EN
    logic [31:0] r_perf_retired;
    logic [31:0] r_perf_flushes;
    logic [31:0] r_perf_full_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_retired     <= '0;
            r_perf_flushes     <= '0;
            r_perf_full_stalls <= '0;
        end else begin
            if (w_retire && !(&r_perf_retired))
                r_perf_retired <= r_perf_retired + 32'd1;
            if (w_flush && !(&r_perf_flushes))
                r_perf_flushes <= r_perf_flushes + 32'd1;
            if (de1_alloc_req && w_full && !(&r_perf_full_stalls))
                r_perf_full_stalls <= r_perf_full_stalls + 32'd1;
        end
    end

    assign perf_retired     = r_perf_retired;
    assign perf_flushes     = r_perf_flushes;
    assign perf_full_stalls = r_perf_full_stalls;
`endif

endmodule
